// File: rtl/fe_pkg.sv
// -----------------------------------------------------------------------------
// fe_pkg
// Shared types and constants for the memory-mapped UART transmitter.
//   uart_state_t : transmitter FSM states
//   UART_ST_*    : bit positions inside the 32-bit status word
//   pack_status  : assembles the status word read back over the bus
// -----------------------------------------------------------------------------
package fe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_ST_BUSY    = 0;
    localparam int UART_ST_FULL    = 1;
    localparam int UART_ST_EMPTY   = 2;
    localparam int UART_ST_OVF     = 3;
    localparam int UART_ST_CNT_LSB = 4;

    // Status word: flags in [3:0], queue occupancy in [7:4], rest zero.
    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic       ovf,
        input logic [3:0] count
    );
        logic [31:0] w;
        w                                       = 32'h0000_0000;
        w[UART_ST_BUSY]                         = busy;
        w[UART_ST_FULL]                         = full;
        w[UART_ST_EMPTY]                        = empty;
        w[UART_ST_OVF]                          = ovf;
        w[UART_ST_CNT_LSB +: 4]                 = count;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO holding bytes waiting to be serialised.
//   clk, rst      : clock, synchronous active-high reset (flushes the queue)
//   push_i, din_i : enqueue din_i; accepted when not full, or when full with a
//                   simultaneous pop
//   pop_i, dout_o : dequeue; dout_o always shows the head entry
//   full_o, empty_o, count_o : occupancy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == CNT_ZERO);
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i & ~empty_o;
    // When full, the slot being vacated by the pop is the one written.
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Next-state for pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// -----------------------------------------------------------------------------
// uart_tx_periph
// Memory-mapped 8N1 UART transmitter (LSB first) with a small TX queue.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   bus_wrdata  : store data, byte in [7:0]
//   uart_wren   : write select; one byte is queued per rising edge
//   uart_rddata : status {24'b0, count[3:0], ovf, empty, full, busy}
//   uart_tx     : registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_periph
    import fe_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_wrdata,
    input  logic        uart_wren,
    output logic [31:0] uart_rddata,
    output logic        uart_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int FCNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    uart_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic              wren_q;

    logic              push_s;
    logic              pop_s;
    logic              baud_end_s;
    logic [7:0]        fifo_dout_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [FCNT_W-1:0] fifo_count_s;
    logic              unused_wrdata_s;

    // A held strobe from the slow bus must queue only one byte.
    assign push_s          = uart_wren & ~wren_q;
    assign baud_end_s      = (baud_q == BAUD_LAST);
    assign unused_wrdata_s = ^bus_wrdata[31:8];

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (bus_wrdata[7:0]),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Frame sequencer: next state, baud/bit counters, shifter and line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = BAUD_ZERO;
                bit_d  = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_dout_s;
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_end_s) begin
                    baud_d  = BAUD_ZERO;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d  = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_end_s) begin
                    baud_d = BAUD_ZERO;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_dout_s;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = BAUD_ZERO;
                bit_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Sticky overflow: a push that finds the queue full with no pop loses its byte.
    always_comb begin
        if (push_s && fifo_full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Sequencer, line and strobe-history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= BAUD_ZERO;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            wren_q  <= uart_wren;
        end
    end

    assign uart_tx     = tx_q;
    assign uart_rddata = pack_status(state_q != IDLE, fifo_full_s, fifo_empty_s,
                                     ovf_q, 4'(fifo_count_s));

endmodule

// File: tb/tb_uart_tx_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_periph
// Directed bench for uart_tx_periph at 8 clocks per bit, 4-entry queue.
// -----------------------------------------------------------------------------
module tb_uart_tx_periph;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_wrdata = 32'h0;
    logic        uart_wren = 1'b0;
    logic [31:0] uart_rddata;
    logic        uart_tx;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // [0] = start bit ... [9] = stop bit
        int         hold;    // cycles uart_wren stays high
    } vec_t;

    vec_t vecs [6];

    uart_tx_periph #(
        .CLK_FREQ_HZ (8),
        .BAUD_RATE   (1),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_wrdata  (bus_wrdata),
        .uart_wren   (uart_wren),
        .uart_rddata (uart_rddata),
        .uart_tx     (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 32'h%08h, required 32'h%08h", name, act, exp);
        end
    endtask

    // Line must stay idle-high with a fixed status word for n cycles.
    task automatic check_idle(input string name, input int n, input logic [31:0] exp_st);
        int          bad   = -1;
        logic        a_tx  = 1'b0;
        logic [31:0] a_st  = 32'h0;
        for (int i = 0; i < n; i++) begin
            if ((uart_tx !== 1'b1 || uart_rddata !== exp_st) && bad < 0) begin
                bad  = i;
                a_tx = uart_tx;
                a_st = uart_rddata;
            end
            tick();
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: cycle %0d tx=%b status=32'h%08h, required tx=1 status=32'h%08h",
                     name, bad, a_tx, a_st, exp_st);
        end
    endtask

    // Compare one frame cycle by cycle from sample index 'start' to 79; returns on the
    // sample right after the frame. Optionally drops/raises uart_wren at given indices.
    task automatic capture(input string name, input logic [9:0] frame, input int start,
                           input int drop_at, input int raise_at);
        int   bad    = -1;
        logic a_tx   = 1'b0;
        logic a_busy = 1'b0;
        logic e_tx   = 1'b0;
        for (int i = start; i < 80; i++) begin
            if ((uart_tx !== frame[i/8] || uart_rddata[0] !== 1'b1) && bad < 0) begin
                bad    = i;
                a_tx   = uart_tx;
                a_busy = uart_rddata[0];
                e_tx   = frame[i/8];
            end
            if (i == drop_at) uart_wren = 1'b0;
            if (i == raise_at) uart_wren = 1'b1;
            tick();
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: sample %0d tx=%b busy=%b, required tx=%b busy=1",
                     name, bad, a_tx, a_busy, e_tx);
        end
    endtask

    // Single-cycle write pulse: accept edge, then one edge with wren low.
    task automatic write_byte(input logic [7:0] d);
        bus_wrdata = {24'hC0FFEE, d};
        uart_wren  = 1'b1;
        tick();
        uart_wren  = 1'b0;
        bus_wrdata = 32'h0;
        tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0, hold: 40};
        vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0, hold: 1};
        vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0, hold: 1};
        vecs[3] = '{data: 8'h80, frame: 10'b1_1000_0000_0, hold: 3};
        vecs[4] = '{data: 8'h3C, frame: 10'b1_0011_1100_0, hold: 1};
        vecs[5] = '{data: 8'h01, frame: 10'b1_0000_0001_0, hold: 1};

        // Reset state and quiet hold.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rst_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_status", uart_rddata, 32'h0000_0004);
        rst = 1'b0;
        check_idle("rst_hold", 20, 32'h4);

        // Single-byte frames; the data bus is scrambled after the accepting edge.
        for (int v = 0; v < 6; v++) begin
            bus_wrdata = {24'hABCDEF, vecs[v].data};
            uart_wren  = 1'b1;
            tick();
            if (vecs[v].hold == 1) uart_wren = 1'b0;
            bus_wrdata = 32'h0000_005A;
            check("accept_status", uart_rddata, 32'h0000_0010);
            check("accept_tx", {31'h0, uart_tx}, 32'h1);
            tick();
            capture("frame", vecs[v].frame, 0, vecs[v].hold - 2, -1);
            uart_wren = 1'b0;
            check_idle("after_frame", 10, 32'h4);
        end

        // Three pulses: contiguous frames, count 2 -> 1 -> 0.
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        check("b2b_count2", uart_rddata, 32'h0000_0021);
        capture("b2b_f1", 10'b1_0000_0001_0, 4, -1, -1);
        check("b2b_count1", uart_rddata, 32'h0000_0011);
        capture("b2b_f2", 10'b1_0000_0010_0, 0, -1, -1);
        check("b2b_count0", uart_rddata, 32'h0000_0005);
        capture("b2b_f3", 10'b1_0000_0011_0, 0, -1, -1);
        check_idle("b2b_idle", 10, 32'h4);

        // Overflow: 5 writes while busy, 5th dropped, sticky flag.
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        write_byte(8'h55);
        write_byte(8'h66);
        check("ovf_full", uart_rddata, 32'h0000_004B);
        capture("ovf_f11", 10'b1_0001_0001_0, 10, -1, -1);
        check("ovf_cnt3", uart_rddata, 32'h0000_0039);
        capture("ovf_f22", 10'b1_0010_0010_0, 0, -1, -1);
        check("ovf_cnt2", uart_rddata, 32'h0000_0029);
        capture("ovf_f33", 10'b1_0011_0011_0, 0, -1, -1);
        check("ovf_cnt1", uart_rddata, 32'h0000_0019);
        capture("ovf_f44", 10'b1_0100_0100_0, 0, -1, -1);
        check("ovf_cnt0", uart_rddata, 32'h0000_000D);
        capture("ovf_f55", 10'b1_0101_0101_0, 0, -1, -1);
        check_idle("ovf_sticky_idle", 20, 32'h0000_000C);

        do_reset(2);
        check("ovf_cleared", uart_rddata, 32'h0000_0004);

        // Push coinciding with a pop while full: accepted, no overflow.
        write_byte(8'h81);
        write_byte(8'hA1);
        write_byte(8'hA2);
        write_byte(8'hA3);
        write_byte(8'hA4);
        check("pp_full", uart_rddata, 32'h0000_0043);
        bus_wrdata = 32'h0000_00EE;
        capture("pp_f81", 10'b1_1000_0001_0, 8, -1, 79);
        uart_wren = 1'b0;
        check("pp_same_cycle", uart_rddata, 32'h0000_0043);
        capture("pp_fA1", 10'b1_1010_0001_0, 0, -1, -1);
        check("pp_cnt3", uart_rddata, 32'h0000_0031);
        capture("pp_fA2", 10'b1_1010_0010_0, 0, -1, -1);
        check("pp_cnt2", uart_rddata, 32'h0000_0021);
        capture("pp_fA3", 10'b1_1010_0011_0, 0, -1, -1);
        check("pp_cnt1", uart_rddata, 32'h0000_0011);
        capture("pp_fA4", 10'b1_1010_0100_0, 0, -1, -1);
        check("pp_cnt0", uart_rddata, 32'h0000_0005);
        capture("pp_fEE", 10'b1_1110_1110_0, 0, -1, -1);
        check_idle("pp_idle", 10, 32'h4);

        // Reset in the middle of data bit 3 with bytes still queued.
        write_byte(8'h0F);
        write_byte(8'h10);
        write_byte(8'h20);
        for (int i = 0; i < 31; i++) tick();
        check("mid_bit3_tx", {31'h0, uart_tx}, 32'h1);
        check("mid_status", uart_rddata, 32'h0000_0021);
        rst = 1'b1;
        tick();
        check("midrst_tx", {31'h0, uart_tx}, 32'h1);
        check("midrst_status", uart_rddata, 32'h0000_0004);
        rst = 1'b0;
        check_idle("midrst_quiet", 100, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
